// File: rtl/spi_pkg.sv
// Shared SPI definitions: field widths, frame size codes and slave FSM states.
package spi_pkg;

    localparam int unsigned DWIDTH     = 32;
    localparam int unsigned AWIDTH     = 12;
    localparam int unsigned CTRL_NBITS = AWIDTH + 3;

    typedef enum logic [1:0] {
        SZ8,
        SZ16,
        SZ32,
        SZ_RSVD
    } spi_size_t;

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        WDATA,
        RDATA,
        ERR
    } spi_slave_state_t;

    function automatic logic [5:0] size_to_nbits(spi_size_t size);
        case (size)
            SZ8:     return 6'd8;
            SZ16:    return 6'd16;
            SZ32:    return 6'd32;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rising/falling pulses
// derived from the synchronized level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            last_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        level = sync_q[SYNC_STAGES-1];
        rise  = level & ~last_q;
        fall  = ~level & last_q;
    end

endmodule

// File: rtl/spi_slave.sv
// SPI target: decodes [WRITE | SIZE | ADDR | DATA] frames from spi_master into a
// register-file write/read port, returning read data on miso. Runs on clk only.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DWIDTH      = spi_pkg::DWIDTH,
    parameter int unsigned AWIDTH      = spi_pkg::AWIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    output logic [AWIDTH-1:0] reg_addr,
    output logic [1:0]        reg_size,
    output logic [DWIDTH-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DWIDTH-1:0] reg_rdata,
    output logic              frame_err
);

    localparam int unsigned CTRL_LEN = AWIDTH + 3;
    localparam int unsigned RX_W     = (DWIDTH > CTRL_LEN) ? DWIDTH : CTRL_LEN;
    localparam logic [5:0]  CTRL_CNT = 6'(CTRL_LEN);

    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ss_lvl, ss_rise, ss_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .rst   (rst),
        .din   (sck),
        .level (sck_lvl),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .din   (mosi),
        .level (mosi_lvl),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk   (clk),
        .rst   (rst),
        .din   (ss_n),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sck_lvl, sck_fall, mosi_rise, mosi_fall, ss_rise, ss_fall};

    spi_slave_state_t  state_q;
    logic [5:0]        bit_cnt;
    logic [RX_W-1:0]   rx_q;
    logic [DWIDTH-1:0] tx_q;
    logic              miso_q;
    logic              miso_oe;

    logic [5:0]          nbits;
    logic                last_bit;
    logic [RX_W-1:0]     rx_next;
    logic [CTRL_LEN-1:0] ctrl_word;
    spi_size_t           ctrl_size;
    logic [DWIDTH-1:0]   tx_load;

    always_comb begin
        nbits     = size_to_nbits(spi_size_t'(reg_size));
        last_bit  = (bit_cnt == nbits - 6'd1);
        rx_next   = {rx_q[RX_W-2:0], mosi_lvl};
        ctrl_word = rx_next[CTRL_LEN-1:0];
        ctrl_size = spi_size_t'(ctrl_word[AWIDTH +: 2]);
        // Left-align the nbits read field so its MSB leaves first.
        tx_load   = reg_rdata << (DWIDTH - 32'(nbits));
    end

    assign miso = (miso_oe && !ss_n) ? miso_q : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt   <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            miso_oe   <= 1'b0;
            reg_addr  <= '0;
            reg_size  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;

            case (state_q)
                IDLE: begin
                    miso_oe <= 1'b0;
                    if (!ss_lvl) begin
                        state_q <= CTRL;
                        bit_cnt <= '0;
                    end
                end

                CTRL: begin
                    miso_oe <= 1'b0;
                    if (ss_lvl) begin
                        // bit_cnt == 0 is the normal gap between frames.
                        state_q   <= IDLE;
                        frame_err <= (bit_cnt != '0);
                        bit_cnt   <= '0;
                    end else if (bit_cnt == CTRL_CNT) begin
                        // reg_re cycle of a read: reg_rdata is valid now.
                        tx_q    <= tx_load;
                        miso_q  <= tx_load[DWIDTH-1];
                        miso_oe <= 1'b1;
                        state_q <= RDATA;
                        bit_cnt <= '0;
                    end else if (sck_rise) begin
                        rx_q <= rx_next;
                        if (bit_cnt == CTRL_CNT - 6'd1) begin
                            if (ctrl_size == SZ_RSVD) begin
                                state_q   <= ERR;
                                frame_err <= 1'b1;
                                bit_cnt   <= '0;
                            end else begin
                                reg_addr <= ctrl_word[AWIDTH-1:0];
                                reg_size <= ctrl_word[AWIDTH +: 2];
                                if (ctrl_word[CTRL_LEN-1]) begin
                                    state_q <= WDATA;
                                    bit_cnt <= '0;
                                    rx_q    <= '0;
                                end else begin
                                    reg_re  <= 1'b1;
                                    bit_cnt <= CTRL_CNT;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end

                WDATA: begin
                    if (ss_lvl) begin
                        state_q   <= IDLE;
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                    end else if (sck_rise) begin
                        rx_q <= rx_next;
                        if (last_bit) begin
                            reg_wdata <= rx_next[DWIDTH-1:0];
                            reg_we    <= 1'b1;
                            state_q   <= CTRL;
                            bit_cnt   <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end

                RDATA: begin
                    if (ss_lvl) begin
                        state_q   <= IDLE;
                        frame_err <= 1'b1;
                        miso_oe   <= 1'b0;
                        bit_cnt   <= '0;
                    end else if (sck_rise) begin
                        // Bit k is presented after rise k and sampled on fall k.
                        miso_q <= tx_q[DWIDTH-1];
                        tx_q   <= {tx_q[DWIDTH-2:0], 1'b0};
                        if (last_bit) begin
                            state_q <= CTRL;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end

                ERR: begin
                    miso_oe <= 1'b0;
                    if (ss_lvl) begin
                        state_q <= IDLE;
                        bit_cnt <= '0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    miso_oe <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: emulates the master's mode-0 framing and checks
// strobes, decoded fields and miso data against hand-computed values.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        mosi;
    logic        ss_n;
    logic        miso;
    logic [11:0] reg_addr;
    logic [1:0]  reg_size;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic        frame_err;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .mosi      (mosi),
        .ss_n      (ss_n),
        .miso      (miso),
        .reg_addr  (reg_addr),
        .reg_size  (reg_size),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err)
    );

    int checks = 0;
    int errors = 0;

    // Strobe monitor and a one-entry register model.
    int          we_cnt = 0, re_cnt = 0, ferr_cnt = 0, both_cnt = 0;
    logic [31:0] w_data = 32'h0;
    logic [11:0] w_addr = 12'h0, r_addr = 12'h0;
    logic [1:0]  w_size = 2'h0;

    assign reg_rdata = (reg_addr == 12'hFFF) ? 32'hDEADBEEF : w_data;

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            w_data = reg_wdata;
            w_addr = reg_addr;
            w_size = reg_size;
        end
        if (reg_re) begin
            re_cnt++;
            r_addr = reg_addr;
        end
        if (frame_err) ferr_cnt++;
        if (reg_we && reg_re) both_cnt++;
    end

    int b_we, b_re, b_ferr;

    task automatic snap();
        b_we   = we_cnt;
        b_re   = re_cnt;
        b_ferr = ferr_cnt;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One SPI clock: mosi set in the low phase, 4 clk low, 4 clk high;
    // miso sampled just before the falling edge.
    task automatic sck_bit(input logic b, output logic s);
        mosi = b;
        repeat (4) @(posedge clk);
        #1 sck = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        s = miso;
        @(posedge clk);
        #1 sck = 1'b0;
    endtask

    task automatic send_frame(input logic w, input logic [1:0] sz, input logic [11:0] addr,
                              input logic [31:0] data, input int nbits, input int maxbits,
                              output logic [31:0] rd);
        logic [14:0] ctrl;
        logic        b;
        logic        s;
        ctrl = {w, sz, addr};
        rd   = 32'h0;
        for (int i = 0; i < 15 + nbits && i < maxbits; i++) begin
            if (i < 15) b = ctrl[14-i];
            else        b = data[nbits-1-(i-15)];
            sck_bit(b, s);
            if (i >= 15) rd = {rd[30:0], s};
        end
    endtask

    task automatic select();
        @(posedge clk);
        #1 ss_n = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic deselect();
        @(posedge clk);
        #1 ss_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        rst  = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        ss_n = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_we",    32'(reg_we), 32'h0);
        check_eq("rst_re",    32'(reg_re), 32'h0);
        check_eq("rst_ferr",  32'(frame_err), 32'h0);
        check_eq("rst_addr",  32'(reg_addr), 32'h0);
        check_eq("rst_size",  32'(reg_size), 32'h0);
        check_eq("rst_wdata", reg_wdata, 32'h0);
        check_eq("rst_miso_z", 32'(miso === 1'bz), 32'h1);
        rst = 1'b0;

        // Write 8b
        snap();
        select();
        send_frame(1'b1, 2'd0, 12'h0A5, 32'h3C, 8, 99, rd);
        deselect();
        check_eq("w8_we_cnt", 32'(we_cnt - b_we), 32'h1);
        check_eq("w8_addr",   32'(w_addr), 32'h0A5);
        check_eq("w8_size",   32'(w_size), 32'h0);
        check_eq("w8_wdata",  w_data, 32'h0000003C);
        check_eq("w8_ferr",   32'(ferr_cnt - b_ferr), 32'h0);

        // Read 32b
        snap();
        select();
        send_frame(1'b0, 2'd2, 12'hFFF, 32'h0, 32, 99, rd);
        repeat (3) @(posedge clk);
        #1 check_eq("r32_miso_z", 32'(miso === 1'bz), 32'h1);
        deselect();
        check_eq("r32_re_cnt", 32'(re_cnt - b_re), 32'h1);
        check_eq("r32_addr",   32'(r_addr), 32'hFFF);
        check_eq("r32_data",   rd, 32'hDEADBEEF);
        check_eq("r32_we_cnt", 32'(we_cnt - b_we), 32'h0);
        check_eq("r32_ferr",   32'(ferr_cnt - b_ferr), 32'h0);

        // Back-to-back write 16b then read 16b, ss_n high for 1 clk
        snap();
        select();
        send_frame(1'b1, 2'd1, 12'h010, 32'h1234, 16, 99, rd);
        @(posedge clk);
        #1 ss_n = 1'b1;
        @(posedge clk);
        #1 ss_n = 1'b0;
        send_frame(1'b0, 2'd1, 12'h010, 32'h0, 16, 99, rd);
        deselect();
        check_eq("b2b_we_cnt", 32'(we_cnt - b_we), 32'h1);
        check_eq("b2b_re_cnt", 32'(re_cnt - b_re), 32'h1);
        check_eq("b2b_ferr",   32'(ferr_cnt - b_ferr), 32'h0);
        check_eq("b2b_wdata",  w_data, 32'h00001234);
        check_eq("b2b_wsize",  32'(w_size), 32'h1);
        check_eq("b2b_rdata",  rd, 32'h00001234);
        check_eq("b2b_both",   32'(both_cnt), 32'h0);

        // Abort after 20 bits of a 32b write
        snap();
        select();
        send_frame(1'b1, 2'd2, 12'h123, 32'hCAFEF00D, 32, 20, rd);
        deselect();
        check_eq("abort_ferr",   32'(ferr_cnt - b_ferr), 32'h1);
        check_eq("abort_we_cnt", 32'(we_cnt - b_we), 32'h0);
        snap();
        select();
        send_frame(1'b1, 2'd0, 12'h001, 32'h81, 8, 99, rd);
        deselect();
        check_eq("post_abort_we",    32'(we_cnt - b_we), 32'h1);
        check_eq("post_abort_wdata", w_data, 32'h00000081);
        check_eq("post_abort_addr",  32'(w_addr), 32'h001);
        check_eq("post_abort_ferr",  32'(ferr_cnt - b_ferr), 32'h0);

        // Invalid size code 3
        snap();
        select();
        send_frame(1'b1, 2'd3, 12'h055, 32'h0, 8, 15, rd);
        repeat (2) @(posedge clk);
        check_eq("rsvd_ferr", 32'(ferr_cnt - b_ferr), 32'h1);
        send_frame(1'b0, 2'd0, 12'h000, 32'h0, 8, 8, rd);
        #1 check_eq("rsvd_miso_z", 32'(miso === 1'bz), 32'h1);
        check_eq("rsvd_we_cnt", 32'(we_cnt - b_we), 32'h0);
        check_eq("rsvd_re_cnt", 32'(re_cnt - b_re), 32'h0);
        deselect();
        check_eq("rsvd_ferr_once", 32'(ferr_cnt - b_ferr), 32'h1);
        snap();
        select();
        send_frame(1'b0, 2'd0, 12'hFFF, 32'h0, 8, 99, rd);
        deselect();
        check_eq("post_rsvd_re",   32'(re_cnt - b_re), 32'h1);
        check_eq("post_rsvd_data", rd, 32'h000000EF);

        // Async reset in the middle of a read data phase
        select();
        send_frame(1'b0, 2'd2, 12'hFFF, 32'h0, 32, 23, rd);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("mid_rst_miso_z", 32'(miso === 1'bz), 32'h1);
        check_eq("mid_rst_we",     32'(reg_we), 32'h0);
        check_eq("mid_rst_re",     32'(reg_re), 32'h0);
        check_eq("mid_rst_ferr",   32'(frame_err), 32'h0);
        check_eq("mid_rst_addr",   32'(reg_addr), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        ss_n = 1'b1;
        repeat (4) @(posedge clk);
        snap();
        select();
        send_frame(1'b1, 2'd2, 12'h3AB, 32'h89ABCDEF, 32, 99, rd);
        deselect();
        check_eq("post_rst_we",    32'(we_cnt - b_we), 32'h1);
        check_eq("post_rst_wdata", w_data, 32'h89ABCDEF);
        check_eq("post_rst_addr",  32'(w_addr), 32'h3AB);
        check_eq("post_rst_ferr",  32'(ferr_cnt - b_ferr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
